// File: rtl/store_buffer.sv
// In-order store queue between two LSU issue lanes and DataMemory, with
// load-after-store hazard detection; define STORE_BUFFER_FWD_EN to forward hits.
module store_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr0,
  input  logic [ADDR_WIDTH-1:0] st_addr1,
  input  logic [DATA_WIDTH-1:0] st_data0,
  input  logic [DATA_WIDTH-1:0] st_data1,
  output logic                  st_ready,
  input  logic                  drain_hold,
  input  logic                  hlt,
  output logic                  drained,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_stall,
  output logic                  ld_hit,
  output logic [DATA_WIDTH-1:0] ld_fwd_data,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [1:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_waddr1,
  output logic [ADDR_WIDTH-1:0] mem_waddr2,
  output logic [DATA_WIDTH-1:0] mem_wdata1,
  output logic [DATA_WIDTH-1:0] mem_wdata2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] entryAddr [DEPTH];
  logic [DATA_WIDTH-1:0] entryData [DEPTH];
  logic [DEPTH-1:0]      entryValid;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;

  logic          stAccept;
  logic          enq0;
  logic          enq1;
  logic [PW-1:0] lane1Slot;
  logic [PW-1:0] headNext;
  logic          deqAllowed;
  logic          deq0;
  logic          deq1;
  logic [CW-1:0] enqNum;
  logic [CW-1:0] deqNum;
  logic          hazard;

  assign st_ready = (count <= CW'(DEPTH - 2));
  assign drained  = (count == '0) && (mem_write == 2'b00);

  // Lane1 lands behind lane0 only when lane0 also stores this cycle.
  assign stAccept  = st_ready & ~hlt;
  assign enq0      = stAccept & st_valid[0];
  assign enq1      = stAccept & st_valid[1];
  assign lane1Slot = enq0 ? tail + PW'(1) : tail;
  assign enqNum    = CW'(enq0) + CW'(enq1);

  // Same-address pair drains one at a time so DataMemory sees writes in order.
  assign headNext   = head + PW'(1);
  assign deqAllowed = ~drain_hold | hlt;
  assign deq0       = deqAllowed && (count != '0);
  assign deq1       = deq0 && (count >= CW'(2)) && (entryAddr[headNext] != entryAddr[head]);
  assign deqNum     = CW'(deq0) + CW'(deq1);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[head + PW'(i)] && (entryAddr[head + PW'(i)] == ld_addr)) hazard = 1'b1;
    end
    if (enq0 && (st_addr0 == ld_addr)) hazard = 1'b1;
    if (enq1 && (st_addr1 == ld_addr)) hazard = 1'b1;
  end

  // NOTE: the entry storage is deliberately not reset; entryValid and count say what is live.
  always_ff @(posedge clk) begin
    if (enq0) begin
      entryAddr[tail] <= st_addr0;
      entryData[tail] <= st_data0;
    end
    if (enq1) begin
      entryAddr[lane1Slot] <= st_addr1;
      entryData[lane1Slot] <= st_data1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      entryValid <= '0;
      mem_write  <= 2'b00;
      mem_waddr1 <= '0;
      mem_waddr2 <= '0;
      mem_wdata1 <= '0;
      mem_wdata2 <= '0;
      mem_read   <= 1'b0;
      mem_raddr  <= '0;
    end else begin
      // Dequeue slots are occupied and enqueue slots free, so these bit updates never collide.
      if (deq0) entryValid[head]      <= 1'b0;
      if (deq1) entryValid[headNext]  <= 1'b0;
      if (enq0) entryValid[tail]      <= 1'b1;
      if (enq1) entryValid[lane1Slot] <= 1'b1;

      head  <= head + PW'(deq0) + PW'(deq1);
      tail  <= tail + PW'(enq0) + PW'(enq1);
      count <= count + enqNum - deqNum;

      mem_write <= {deq1, deq0};
      if (deq0) begin
        mem_waddr1 <= entryAddr[head];
        mem_wdata1 <= entryData[head];
      end
      if (deq1) begin
        mem_waddr2 <= entryAddr[headNext];
        mem_wdata2 <= entryData[headNext];
      end

      mem_read <= ld_req & ~hazard;
      if (ld_req && !hazard) mem_raddr <= ld_addr;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [DATA_WIDTH-1:0] fwdData;

  // Scan oldest to newest, then lane0, then lane1: the last match is the youngest store.
  always_comb begin
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[head + PW'(i)] && (entryAddr[head + PW'(i)] == ld_addr)) begin
        fwdData = entryData[head + PW'(i)];
      end
    end
    if (enq0 && (st_addr0 == ld_addr)) fwdData = st_data0;
    if (enq1 && (st_addr1 == ld_addr)) fwdData = st_data1;
  end

  assign ld_stall = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_hit      <= 1'b0;
      ld_fwd_data <= '0;
    end else begin
      ld_hit <= ld_req & hazard;
      if (ld_req && hazard) ld_fwd_data <= fwdData;
    end
  end
`else
  assign ld_stall    = ld_req & hazard;
  assign ld_hit      = 1'b0;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table for the steady-state flow,
// then hand-written sequences for reset mid-drain, load hazards and hlt drain.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic [1:0]  st_valid;
  logic [15:0] st_addr0, st_addr1, st_data0, st_data1;
  logic        st_ready;
  logic        drain_hold, hlt, drained;
  logic        ld_req;
  logic [15:0] ld_addr;
  logic        ld_stall, ld_hit;
  logic [15:0] ld_fwd_data;
  logic        mem_read;
  logic [15:0] mem_raddr;
  logic [1:0]  mem_write;
  logic [15:0] mem_waddr1, mem_waddr2, mem_wdata1, mem_wdata2;

  int testsRun = 0;
  int testsFailed = 0;

  store_buffer #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr0(st_addr0), .st_addr1(st_addr1),
    .st_data0(st_data0), .st_data1(st_data1), .st_ready(st_ready),
    .drain_hold(drain_hold), .hlt(hlt), .drained(drained),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
    .mem_read(mem_read), .mem_raddr(mem_raddr),
    .mem_write(mem_write), .mem_waddr1(mem_waddr1), .mem_waddr2(mem_waddr2),
    .mem_wdata1(mem_wdata1), .mem_wdata2(mem_wdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for one cycle and the outputs expected while they are applied.
  typedef struct {
    logic [1:0]  stv;
    logic [15:0] a0, d0, a1, d1;
    logic        hold;
    logic        ldReq;
    logic [15:0] ldAddr;
    logic        rdy, drn;
    logic [1:0]  mw;
    logic [15:0] wa1, wd1, wa2, wd2;
    logic        mr;
    logic [15:0] ra;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mkVec(
    input logic [1:0] stv, input logic [15:0] a0, d0, a1, d1,
    input logic hold, input logic ldReq, input logic [15:0] ldAddr,
    input logic rdy, drn, input logic [1:0] mw,
    input logic [15:0] wa1, wd1, wa2, wd2, input logic mr, input logic [15:0] ra);
    vec_t v;
    v.stv = stv; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    v.hold = hold; v.ldReq = ldReq; v.ldAddr = ldAddr;
    v.rdy = rdy; v.drn = drn; v.mw = mw;
    v.wa1 = wa1; v.wd1 = wd1; v.wa2 = wa2; v.wd2 = wd2;
    v.mr = mr; v.ra = ra;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] stv, input logic [15:0] a0, d0, a1, d1,
                       input logic hold, input logic h, input logic lr, input logic [15:0] la);
    st_valid = stv; st_addr0 = a0; st_data0 = d0; st_addr1 = a1; st_data1 = d1;
    drain_hold = hold; hlt = h; ld_req = lr; ld_addr = la;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    // Steady flow: pair drain, same-address split, plain load, fill to full with wrap.
    tbl[0]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkVec(2'b11, 16'h10, 16'h1111, 16'h11, 16'h2222, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 16'h10, 16'h1111, 16'h11, 16'h2222, 0, 0);
    tbl[4]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mkVec(2'b11, 16'h20, 16'hAAAA, 16'h20, 16'hBBBB, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 16'h20, 16'hAAAA, 0, 0, 0, 0);
    tbl[8]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 16'h20, 16'hBBBB, 0, 0, 0, 0);
    tbl[9]  = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[10] = mkVec(2'b00, 0, 0, 0, 0, 0, 1, 16'h40, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[11] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 1, 16'h40);
    tbl[12] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[13] = mkVec(2'b11, 16'h50, 16'h5000, 16'h51, 16'h5001, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[14] = mkVec(2'b11, 16'h52, 16'h5002, 16'h53, 16'h5003, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[15] = mkVec(2'b11, 16'h54, 16'h5004, 16'h55, 16'h5005, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[16] = mkVec(2'b11, 16'h56, 16'h5006, 16'h57, 16'h5007, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[17] = mkVec(2'b11, 16'h58, 16'h5008, 16'h59, 16'h5009, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[18] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[19] = mkVec(2'b00, 0, 0, 0, 0, 0, 1, 16'h99, 1, 0, 2'b11, 16'h50, 16'h5000, 16'h51, 16'h5001, 0, 0);
    tbl[20] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 16'h52, 16'h5002, 16'h53, 16'h5003, 1, 16'h99);
    tbl[21] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 16'h54, 16'h5004, 16'h55, 16'h5005, 0, 0);
    tbl[22] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 16'h56, 16'h5006, 16'h57, 16'h5007, 0, 0);
    tbl[23] = mkVec(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (2) nextCycle();
    check("reset st_ready", st_ready, 1);
    check("reset drained", drained, 1);
    check("reset mem_write", mem_write, 0);
    check("reset mem_read", mem_read, 0);
    check("reset ld_stall", ld_stall, 0);
    check("reset ld_hit", ld_hit, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      nextCycle();
      drive(tbl[i].stv, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1,
            tbl[i].hold, 1'b0, tbl[i].ldReq, tbl[i].ldAddr);
      #1;
      check($sformatf("v%0d st_ready", i), st_ready, tbl[i].rdy);
      check($sformatf("v%0d drained", i), drained, tbl[i].drn);
      check($sformatf("v%0d ld_stall", i), ld_stall, 0);
      check($sformatf("v%0d mem_write", i), mem_write, tbl[i].mw);
      check($sformatf("v%0d mem_read", i), mem_read, tbl[i].mr);
      if (tbl[i].mr) check($sformatf("v%0d mem_raddr", i), mem_raddr, tbl[i].ra);
      if (tbl[i].mw[0]) begin
        check($sformatf("v%0d waddr1", i), mem_waddr1, tbl[i].wa1);
        check($sformatf("v%0d wdata1", i), mem_wdata1, tbl[i].wd1);
      end
      if (tbl[i].mw[1]) begin
        check($sformatf("v%0d waddr2", i), mem_waddr2, tbl[i].wa2);
        check($sformatf("v%0d wdata2", i), mem_wdata2, tbl[i].wd2);
      end
    end

    // Reset while a drain is in flight with five entries queued.
    nextCycle(); drive(2'b11, 16'h60, 16'h6000, 16'h61, 16'h6001, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b11, 16'h62, 16'h6002, 16'h63, 16'h6003, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b01, 16'h64, 16'h6004, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    nextCycle(); #1;
    check("rst-drain mem_write before reset", mem_write, 2'b11);
    reset = 1'b1; #1;
    check("rst-drain mem_write", mem_write, 0);
    check("rst-drain st_ready", st_ready, 1);
    check("rst-drain drained", drained, 1);
    nextCycle(); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nextCycle(); #1;
      check($sformatf("rst-drain discarded c%0d mem_write", i), mem_write, 0);
      check($sformatf("rst-drain discarded c%0d drained", i), drained, 1);
    end

    // Load hazards: lane1 store and a queued entry to the same address.
    nextCycle(); drive(2'b01, 16'h30, 16'h1234, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b10, 16'h0, 16'h0, 16'h30, 16'h5678, 1'b1, 1'b0, 1'b1, 16'h30);
    #1;
`ifdef STORE_BUFFER_FWD_EN
    check("haz lane1 ld_stall", ld_stall, 0);
`else
    check("haz lane1 ld_stall", ld_stall, 1);
`endif
    nextCycle(); drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 16'h30);
    #1;
    check("haz lane1 mem_read", mem_read, 0);
`ifdef STORE_BUFFER_FWD_EN
    check("haz lane1 ld_hit", ld_hit, 1);
    check("haz lane1 ld_fwd_data", ld_fwd_data, 16'h5678);
    check("haz queued ld_stall", ld_stall, 0);
`else
    check("haz lane1 ld_hit", ld_hit, 0);
    check("haz queued ld_stall", ld_stall, 1);
`endif
    nextCycle(); drive(2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 16'h31);
    #1;
    check("haz queued mem_read", mem_read, 0);
    check("miss ld_stall", ld_stall, 0);
`ifdef STORE_BUFFER_FWD_EN
    check("haz queued ld_hit", ld_hit, 1);
    check("haz queued ld_fwd_data", ld_fwd_data, 16'h5678);
`endif
    nextCycle(); drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    check("miss mem_read", mem_read, 1);
    check("miss mem_raddr", mem_raddr, 16'h31);
    check("miss ld_hit", ld_hit, 0);
    nextCycle(); #1;
    check("haz drain1 mem_write", mem_write, 2'b01);
    check("haz drain1 wdata1", mem_wdata1, 16'h1234);
    nextCycle(); #1;
    check("haz drain2 mem_write", mem_write, 2'b01);
    check("haz drain2 wdata1", mem_wdata1, 16'h5678);
    nextCycle(); #1;
    check("haz drained", drained, 1);

    // hlt forces the drain past drain_hold and blocks new stores.
    nextCycle(); drive(2'b11, 16'h70, 16'h7000, 16'h71, 16'h7001, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b11, 16'h72, 16'h7002, 16'h73, 16'h7003, 1'b1, 1'b0, 1'b0, 16'h0);
    nextCycle(); drive(2'b11, 16'h80, 16'h8000, 16'h81, 16'h8001, 1'b1, 1'b1, 1'b0, 16'h0);
    #1;
    check("hlt st_ready count4", st_ready, 1);
    check("hlt drained start", drained, 0);
    nextCycle(); #1;
    check("hlt drain1 mem_write", mem_write, 2'b11);
    check("hlt drain1 waddr1", mem_waddr1, 16'h70);
    check("hlt drain1 waddr2", mem_waddr2, 16'h71);
    nextCycle(); #1;
    check("hlt drain2 mem_write", mem_write, 2'b11);
    check("hlt drain2 wdata1", mem_wdata1, 16'h7002);
    check("hlt drain2 wdata2", mem_wdata2, 16'h7003);
    check("hlt drain2 drained", drained, 0);
    for (int i = 0; i < 2; i++) begin
      nextCycle(); #1;
      check($sformatf("hlt after c%0d drained", i), drained, 1);
      check($sformatf("hlt after c%0d mem_write", i), mem_write, 0);
    end
    nextCycle(); drive(2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
